// File: rtl/mario_coin_tracker_pkg.sv
// Shared types and constants for the Mario game layer: tile classes, coin slot,
// scan FSM states and the inset-hitbox corner calculation.
package mario_pkg;

  localparam int CHARACTER_WIDTH = 42;
  localparam int BLOCK_WIDTH     = 40;
  localparam int HIT_INSET       = 10;
  localparam int SCREEN_WIDTH    = 640;
  localparam int SCREEN_HEIGHT   = 480;

  localparam int unsigned COLS     = int'(SCREEN_WIDTH / BLOCK_WIDTH);
  localparam int unsigned ROWS     = int'(SCREEN_HEIGHT / BLOCK_WIDTH);
  localparam int unsigned COL_W    = $clog2(COLS);
  localparam int unsigned ROW_W    = $clog2(ROWS);
  localparam int unsigned CORNER_W = 32;

  localparam logic [2:0] BDR = 3'd0;
  localparam logic [2:0] SKY = 3'd1;
  localparam logic [2:0] BLK = 3'd2;
  localparam logic [2:0] GND = 3'd3;
  localparam logic [2:0] TKN = 3'd4;

  typedef struct packed {
    logic             armed;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } coin_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CORNER_W-1:0] l;
    logic [CORNER_W-1:0] r;
    logic [CORNER_W-1:0] t;
    logic [CORNER_W-1:0] b;
    logic                l_ok;
    logic                r_ok;
    logic                t_ok;
    logic                b_ok;
  } corners_t;

  // An edge whose pre-division operand is negative is flagged invalid.
  function automatic corners_t hitbox_corners(input int x, input int y,
                                              input int inset   = HIT_INSET,
                                              input int char_w  = CHARACTER_WIDTH,
                                              input int block_w = BLOCK_WIDTH);
    corners_t c;
    int nl, nr, nt, nb;
    nl = x + inset;
    nr = x - inset + char_w;
    nt = y + inset;
    nb = y - inset + char_w;
    c.l_ok = (nl >= 0);
    c.r_ok = (nr >= 0);
    c.t_ok = (nt >= 0);
    c.b_ok = (nb >= 0);
    c.l = CORNER_W'(nl / block_w);
    c.r = CORNER_W'(nr / block_w);
    c.t = CORNER_W'(nt / block_w);
    c.b = CORNER_W'(nb / block_w);
    return c;
  endfunction

endpackage

// File: rtl/mario_coin_tracker_hitbox.sv
// Registered hitbox corner calculator; latches Mario's tile corners on i_load.
module mario_hitbox
  import mario_pkg::*;
#(
  parameter int CHAR_W  = CHARACTER_WIDTH,
  parameter int BLOCK_W = BLOCK_WIDTH,
  parameter int INSET   = HIT_INSET
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic signed [31:0] i_x,
  input  logic signed [31:0] i_y,
  output corners_t           o_corners
);

  corners_t r_corners;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corners <= '0;
    end else if (i_load) begin
      r_corners <= hitbox_corners(int'(i_x), int'(i_y), INSET, CHAR_W, BLOCK_W);
    end
  end

  assign o_corners = r_corners;

endmodule

// File: rtl/mario_coin_tracker.sv
// Coin table with a once-per-frame sequential scan against Mario's hitbox,
// collect events, saturating score and per-tile visibility queries.
module mario_coin_tracker
  import mario_pkg::*;
#(
  parameter int unsigned NUM_COINS       = 16,
  parameter int          CHARACTER_WIDTH = mario_pkg::CHARACTER_WIDTH,
  parameter int          BLOCK_WIDTH     = mario_pkg::BLOCK_WIDTH,
  parameter int          HIT_INSET       = mario_pkg::HIT_INSET,
  parameter int unsigned SCORE_WIDTH     = 16,
  parameter int unsigned COIN_VALUE      = 1,
  localparam int unsigned IDX_W          = $clog2(NUM_COINS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic signed [31:0]     mario_x,
  input  logic signed [31:0]     mario_y,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [COL_W-1:0]       wr_col,
  input  logic [ROW_W-1:0]       wr_row,
  input  logic                   wr_en,
  input  logic [COL_W-1:0]       q_col,
  input  logic [ROW_W-1:0]       q_row,
  output logic                   q_hit,
  output logic [NUM_COINS-1:0]   coin_visible,
  output logic                   collect_valid,
  output logic [IDX_W-1:0]       collect_idx,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   scan_done,
  output logic                   all_collected
);

  localparam int unsigned CNT_W = $clog2(NUM_COINS + 1);
  localparam int unsigned SUM_W = SCORE_WIDTH + 1;

  state_t                 r_state, w_state_next;
  coin_slot_t             r_slots [NUM_COINS];
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_armed_cnt, w_cnt_next;
  logic                   r_ever_armed;
  logic [SCORE_WIDTH-1:0] r_score, w_score_sat;
  logic [SUM_W-1:0]       w_score_sum;
  logic                   r_wr_ready, r_q_hit, r_collect_valid, r_scan_done, r_all_collected;
  logic [IDX_W-1:0]       r_collect_idx;
  logic                   w_load, w_scan, w_scan_end, w_wr_fire, w_touch, w_corner_hit;
  logic                   w_arm_inc, w_arm_dec, w_q_match;
  corners_t               w_c;
  coin_slot_t             w_cur;
  logic [CORNER_W-1:0]    w_col, w_row;

  mario_hitbox #(
    .CHAR_W  (CHARACTER_WIDTH),
    .BLOCK_W (BLOCK_WIDTH),
    .INSET   (HIT_INSET)
  ) u_hitbox (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_x       (mario_x),
    .i_y       (mario_y),
    .o_corners (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (frame_start) w_state_next = ST_SCAN;
      ST_SCAN: if (r_idx == IDX_W'(NUM_COINS - 1)) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = 1'b0;
    w_scan     = 1'b0;
    w_scan_end = 1'b0;
    case (r_state)
      ST_IDLE: w_load = frame_start;
      ST_SCAN: begin
        w_scan     = 1'b1;
        w_scan_end = (r_idx == IDX_W'(NUM_COINS - 1));
      end
      default: ;
    endcase
  end

  // Slot under test against the four latched corners.
  assign w_cur = r_slots[r_idx];
  assign w_col = CORNER_W'(w_cur.col);
  assign w_row = CORNER_W'(w_cur.row);
  assign w_corner_hit = (w_c.l_ok && w_c.t_ok && w_c.l == w_col && w_c.t == w_row) ||
                        (w_c.l_ok && w_c.b_ok && w_c.l == w_col && w_c.b == w_row) ||
                        (w_c.r_ok && w_c.t_ok && w_c.r == w_col && w_c.t == w_row) ||
                        (w_c.r_ok && w_c.b_ok && w_c.r == w_col && w_c.b == w_row);
  assign w_touch   = w_scan && w_cur.armed && w_corner_hit;
  assign w_wr_fire = wr_valid && r_wr_ready;

  assign w_arm_inc = w_wr_fire && wr_en && !r_slots[wr_idx].armed;
  assign w_arm_dec = (w_wr_fire && !wr_en && r_slots[wr_idx].armed) || w_touch;

  always_comb begin
    w_cnt_next = r_armed_cnt;
    if (w_arm_inc && !w_arm_dec)      w_cnt_next = r_armed_cnt + CNT_W'(1);
    else if (w_arm_dec && !w_arm_inc) w_cnt_next = r_armed_cnt - CNT_W'(1);
  end

  assign w_score_sum = {1'b0, r_score} + SUM_W'(COIN_VALUE);
  assign w_score_sat = w_score_sum[SCORE_WIDTH] ? '1 : w_score_sum[SCORE_WIDTH-1:0];

  always_comb begin
    w_q_match    = 1'b0;
    coin_visible = '0;
    for (int i = 0; i < int'(NUM_COINS); i++) begin
      coin_visible[i] = r_slots[i].armed;
      if (r_slots[i].armed && r_slots[i].col == q_col && r_slots[i].row == q_row)
        w_q_match = 1'b1;
    end
  end

  // Table writes only land in IDLE, touches only in SCAN, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_COINS); i++) r_slots[i] <= '0;
      r_idx <= '0;
    end else begin
      if (w_wr_fire) r_slots[wr_idx] <= '{armed: wr_en, col: wr_col, row: wr_row};
      if (w_touch)   r_slots[r_idx].armed <= 1'b0;
      if (w_load)      r_idx <= '0;
      else if (w_scan) r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ready      <= 1'b0;
      r_q_hit         <= 1'b0;
      r_collect_valid <= 1'b0;
      r_collect_idx   <= '0;
      r_scan_done     <= 1'b0;
      r_score         <= '0;
      r_armed_cnt     <= '0;
      r_ever_armed    <= 1'b0;
      r_all_collected <= 1'b0;
    end else begin
      r_wr_ready      <= (w_state_next == ST_IDLE);
      r_q_hit         <= w_q_match;
      r_collect_valid <= w_touch;
      if (w_touch) begin
        r_collect_idx <= r_idx;
        r_score       <= w_score_sat;
      end
      r_scan_done     <= w_scan_end;
      r_armed_cnt     <= w_cnt_next;
      r_ever_armed    <= r_ever_armed | w_arm_inc;
      r_all_collected <= (w_cnt_next == '0) && (r_ever_armed || w_arm_inc);
    end
  end

  assign wr_ready      = r_wr_ready;
  assign q_hit         = r_q_hit;
  assign collect_valid = r_collect_valid;
  assign collect_idx   = r_collect_idx;
  assign score         = r_score;
  assign scan_done     = r_scan_done;
  assign all_collected = r_all_collected;

endmodule

// File: tb/tb_mario_coin_tracker.sv
// Scenario-driven bench for mario_coin_tracker; collect events are checked
// against a queue of expected (slot, cycle) entries.
module tb_mario_coin_tracker;
  import mario_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_start = 1'b0;
  logic signed [31:0] mario_x = '0, mario_y = '0;
  logic               wr_valid = 1'b0, wr_en = 1'b0;
  logic [IW-1:0]      wr_idx = '0;
  logic [COL_W-1:0]   wr_col = '0, q_col = '0;
  logic [ROW_W-1:0]   wr_row = '0, q_row = '0;

  logic          wr_ready, q_hit, collect_valid, scan_done, all_collected;
  logic [N-1:0]  coin_visible;
  logic [IW-1:0] collect_idx;
  logic [15:0]   score;

  logic          wr_ready2, q_hit2, collect_valid2, scan_done2, all_collected2;
  logic [N-1:0]  coin_visible2;
  logic [IW-1:0] collect_idx2;
  logic [1:0]    score2;

  mario_coin_tracker u_dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mario_x(mario_x), .mario_y(mario_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_col(wr_col), .wr_row(wr_row),
    .wr_en(wr_en), .q_col(q_col), .q_row(q_row), .q_hit(q_hit), .coin_visible(coin_visible),
    .collect_valid(collect_valid), .collect_idx(collect_idx), .score(score),
    .scan_done(scan_done), .all_collected(all_collected)
  );

  mario_coin_tracker #(.SCORE_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mario_x(mario_x), .mario_y(mario_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_idx(wr_idx), .wr_col(wr_col), .wr_row(wr_row),
    .wr_en(wr_en), .q_col(q_col), .q_row(q_row), .q_hit(q_hit2), .coin_visible(coin_visible2),
    .collect_valid(collect_valid2), .collect_idx(collect_idx2), .score(score2),
    .scan_done(scan_done2), .all_collected(all_collected2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; int due; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0, n_err = 0;
  int   exp_score = 0, exp_score2 = 0;

  // Scoreboard: every collect pulse must match the oldest expected entry.
  always @(posedge clk) begin
    #1;
    if (collect_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL collect_unexpected: got idx=%0d at cyc=%0d, required no event", collect_idx, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (collect_idx !== IW'(mon_e.idx) || cyc != mon_e.due) begin
          n_err++;
          $display("FAIL collect_event: got idx=%0d cyc=%0d, required idx=%0d cyc=%0d",
                   collect_idx, cyc, mon_e.idx, mon_e.due);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_score();
    exp_score  = (exp_score + 1 > 65535) ? 65535 : exp_score + 1;
    exp_score2 = (exp_score2 + 1 > 3) ? 3 : exp_score2 + 1;
  endtask

  task automatic write_slot(input int idx, input int col, input int row, input bit en);
    for (int k = 0; k < 40 && wr_ready !== 1'b1; k++) tick();
    wr_valid = 1'b1; wr_idx = IW'(idx); wr_col = COL_W'(col); wr_row = ROW_W'(row); wr_en = en;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_frame(input int x, input int y, input logic [N-1:0] mask);
    int  c0, done_cyc;
    bit  got;
    mario_x = x; mario_y = y;
    frame_start = 1'b1;
    c0 = cyc;
    for (int s = 0; s < int'(N); s++)
      if (mask[s]) begin
        exp_q.push_back('{s, c0 + s + 2});
        bump_score();
      end
    tick();
    frame_start = 1'b0;
    got = 0; done_cyc = -1;
    for (int k = 0; k < int'(N) + 4 && !got; k++) begin
      if (scan_done === 1'b1) begin got = 1; done_cyc = cyc; end
      else tick();
    end
    n_vec++;
    if (!got || done_cyc != c0 + int'(N) + 1) begin
      n_err++;
      $display("FAIL scan_done_timing: got cyc=%0d, required cyc=%0d", done_cyc, c0 + int'(N) + 1);
    end
    tick();
    n_vec++;
    if (exp_q.size() != 0 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL frame_end: pending=%0d wr_ready=%b, required pending=0 wr_ready=1", exp_q.size(), wr_ready);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    tick(); tick();
    n_vec++;
    if ({wr_ready, q_hit, coin_visible, collect_valid, collect_idx, score, scan_done, all_collected} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vis=%h score=%0d done=%b all=%b, required all 0",
               wr_ready, coin_visible, score, scan_done, all_collected);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, required 1", wr_ready); end
    write_slot(0, 3, 5, 1'b1);
    n_vec++;
    if (coin_visible !== 16'h0001) begin n_err++; $display("FAIL reset_arm: got vis=%h, required 0001", coin_visible); end
    mario_x = 400; mario_y = 400;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({wr_ready, q_hit, coin_visible, collect_valid, collect_idx, score, scan_done, all_collected} !== '0) begin
      n_err++;
      $display("FAIL reset_midscan: got rdy=%b vis=%h done=%b all=%b, required all 0",
               wr_ready, coin_visible, scan_done, all_collected);
    end
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 2 * int'(N); k++) begin
      tick();
      if (scan_done !== 1'b0 || collect_valid !== 1'b0 || coin_visible !== '0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL reset_abort: got %0d active cycles, required 0", bad); end
    exp_score = 0; exp_score2 = 0;
  endtask

  task automatic test_single();
    write_slot(2, 1, 1, 1'b1);
    q_col = 1; q_row = 1;
    tick();
    n_vec++;
    if (q_hit !== 1'b1) begin n_err++; $display("FAIL query_hit: got %b, required 1", q_hit); end
    q_col = 2;
    tick();
    n_vec++;
    if (q_hit !== 1'b0) begin n_err++; $display("FAIL query_miss: got %b, required 0", q_hit); end
    do_frame(40, 40, 16'h0004);
    n_vec++;
    if (score !== 16'(exp_score) || coin_visible !== '0 || all_collected !== 1'b1) begin
      n_err++;
      $display("FAIL single_collect: got score=%0d vis=%h all=%b, required score=%0d vis=0 all=1",
               score, coin_visible, all_collected, exp_score);
    end
    q_col = 1; q_row = 1;
    tick();
    n_vec++;
    if (q_hit !== 1'b0) begin n_err++; $display("FAIL query_after_collect: got %b, required 0", q_hit); end
    do_frame(40, 40, 16'h0000);
    n_vec++;
    if (score !== 16'(exp_score)) begin n_err++; $display("FAIL no_recollect: got score=%0d, required %0d", score, exp_score); end
  endtask

  task automatic test_corners();
    write_slot(5, 3, 3, 1'b1);
    write_slot(6, 4, 2, 1'b1);
    write_slot(7, 2, 3, 1'b1);
    do_frame(100, 100, 16'h00A0);
    n_vec++;
    if (coin_visible !== 16'h0040 || all_collected !== 1'b0 || score !== 16'(exp_score)) begin
      n_err++;
      $display("FAIL corner_select: got vis=%h all=%b score=%0d, required vis=0040 all=0 score=%0d",
               coin_visible, all_collected, score, exp_score);
    end
    write_slot(6, 4, 2, 1'b0);
    n_vec++;
    if (coin_visible !== '0 || all_collected !== 1'b1) begin
      n_err++;
      $display("FAIL disarm_count: got vis=%h all=%b, required vis=0 all=1", coin_visible, all_collected);
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) write_slot(s, 2, 2, 1'b1);
    do_frame(75, 75, 16'h000F);
    n_vec++;
    if (score !== 16'(exp_score) || all_collected !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_back: got score=%0d all=%b, required score=%0d all=1", score, all_collected, exp_score);
    end
  endtask

  task automatic test_negative();
    write_slot(0, 0, 0, 1'b1);
    write_slot(1, 0, 1, 1'b1);
    write_slot(2, 15, 1, 1'b1);
    do_frame(-20, 40, 16'h0002);
    n_vec++;
    if (coin_visible !== 16'h0005) begin n_err++; $display("FAIL neg_left: got vis=%h, required 0005", coin_visible); end
    do_frame(-100, 40, 16'h0000);
    n_vec++;
    if (coin_visible !== 16'h0005) begin n_err++; $display("FAIL neg_both: got vis=%h, required 0005", coin_visible); end
    write_slot(3, 1, 0, 1'b1);
    do_frame(40, -20, 16'h0008);
    n_vec++;
    if (coin_visible !== 16'h0005 || score !== 16'(exp_score)) begin
      n_err++;
      $display("FAIL neg_top: got vis=%h score=%0d, required vis=0005 score=%0d", coin_visible, score, exp_score);
    end
    write_slot(0, 0, 0, 1'b0);
    write_slot(2, 15, 1, 1'b0);
    n_vec++;
    if (all_collected !== 1'b1) begin n_err++; $display("FAIL neg_cleanup: got all=%b, required 1", all_collected); end
  endtask

  task automatic test_frame_write_same();
    int c0, bad_ready, n_done, done_cyc;
    mario_x = 75; mario_y = 75;
    wr_valid = 1'b1; wr_idx = 3; wr_col = 2; wr_row = 2; wr_en = 1'b1;
    frame_start = 1'b1;
    c0 = cyc;
    exp_q.push_back('{3, c0 + 5});
    bump_score();
    tick();
    wr_valid = 1'b0; frame_start = 1'b0;
    bad_ready = 0; n_done = 0; done_cyc = -1;
    for (int k = 1; k <= 2 * int'(N) + 6; k++) begin
      if (k <= int'(N) + 1 && wr_ready !== 1'b0) bad_ready++;
      if (scan_done === 1'b1) begin n_done++; done_cyc = cyc; end
      frame_start = (k == 5);
      tick();
    end
    n_vec++;
    if (bad_ready != 0) begin n_err++; $display("FAIL scan_ready_low: got %0d ready cycles, required 0", bad_ready); end
    n_vec++;
    if (n_done != 1 || done_cyc != c0 + int'(N) + 1) begin
      n_err++;
      $display("FAIL single_scan: got %0d pulses last cyc=%0d, required 1 at cyc=%0d", n_done, done_cyc, c0 + int'(N) + 1);
    end
    n_vec++;
    if (exp_q.size() != 0 || score !== 16'(exp_score) || all_collected !== 1'b1 || wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL write_then_scan: got pending=%0d score=%0d all=%b rdy=%b, required 0 %0d 1 1",
               exp_q.size(), score, all_collected, wr_ready, exp_score);
      exp_q.delete();
    end
  endtask

  task automatic test_saturate();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_score = 0; exp_score2 = 0;
    n_vec++;
    if (score2 !== 2'd0 || score !== 16'd0) begin n_err++; $display("FAIL sat_reset: got score=%0d score2=%0d, required 0 0", score, score2); end
    write_slot(0, 9, 9, 1'b1);
    for (int s = 1; s < 5; s++) write_slot(s, 2, 2, 1'b1);
    write_slot(0, 2, 2, 1'b1);
    n_vec++;
    if (coin_visible !== 16'h001F || all_collected !== 1'b0) begin
      n_err++;
      $display("FAIL sat_arm: got vis=%h all=%b, required vis=001f all=0", coin_visible, all_collected);
    end
    do_frame(75, 75, 16'h001F);
    n_vec++;
    if (score2 !== 2'(exp_score2) || score !== 16'(exp_score) || all_collected !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: got score=%0d score2=%0d all=%b, required score=%0d score2=%0d all=1",
               score, score2, all_collected, exp_score, exp_score2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_back_to_back();
    test_negative();
    test_frame_write_same();
    test_saturate();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
